// File: rtl/fft_arith_pkg.sv
// Shared arithmetic definitions for the FFT butterfly datapath blocks.
package fft_arith_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

    function automatic int unsigned sub_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one sub_cell iterated LSB-first over N cycles.
module serial_subtractor
    import fft_arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int unsigned CW = sub_cnt_width(N);

    sub_state_t    r_state, w_next;
    logic [N-1:0]  r_a_sr, r_b_sr, r_diff;
    logic [N-2:0]  r_diff_sr;
    logic [CW-1:0] r_cnt;
    logic          r_bin, r_a_sign, r_b_sign, r_borrow, r_ovf;
    logic          w_d, w_bout, w_last;
    logic [N-1:0]  w_diff_next;

    sub_cell u_cell (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // The shift register only keeps the N-1 bits already produced; the
    // current cell output completes the full word on the final cycle.
    assign w_diff_next = {w_d, r_diff_sr};
    assign w_last      = (r_cnt == CW'(N - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = SHIFT;
            SHIFT:   if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_diff_sr <= '0;
            r_diff    <= '0;
            r_cnt     <= '0;
            r_bin     <= 1'b0;
            r_a_sign  <= 1'b0;
            r_b_sign  <= 1'b0;
            r_borrow  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a_sr   <= a;
                r_b_sr   <= b;
                r_a_sign <= a[N-1];
                r_b_sign <= b[N-1];
                r_bin    <= 1'b0;
                r_cnt    <= '0;
            end else if (r_state == SHIFT) begin
                r_a_sr    <= r_a_sr >> 1;
                r_b_sr    <= r_b_sr >> 1;
                r_diff_sr <= w_diff_next[N-1:1];
                r_bin     <= w_bout;
                if (w_last) begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bout;
                    r_ovf    <= (r_a_sign != r_b_sign) && (w_d != r_a_sign);
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (N=8) against hand-computed results.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_ready, out_valid, borrow_out, overflow;
    logic [7:0] diff;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input int stall,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        logic [7:0] held;
        a = ia;
        b = ib;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("shift_busy", in_ready, 0);
        wait_valid(n);
        chk("latency", n, 9);
        chk("diff", diff, ed);
        chk("borrow", borrow_out, eb);
        chk("overflow", overflow, eo);
        held = diff;
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_diff", diff, held);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready, 1);
    endtask

    initial begin
        int n;
        logic [7:0] ra, rb, rd;
        int sd;

        // Reset state
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        step();

        // Directed vectors
        run_op(8'h05, 8'h03, 0, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 0, 8'hFE, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 2, 8'h80, 1'b1, 1'b1);

        // Backpressure with in_valid asserted during the stall
        a = 8'h10;
        b = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        chk("bp_latency", n, 9);
        a = 8'hAA;
        b = 8'h55;
        in_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_diff", diff, 8'h0F);
            chk("bp_in_ready", in_ready, 0);
        end
        a = 8'h22;
        b = 8'h11;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_handshake_valid", out_valid, 0);
        chk("bp_handshake_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_next_accept", in_ready, 0);
        wait_valid(n);
        chk("bp_next_latency", n, 9);
        chk("bp_next_diff", diff, 8'h11);
        chk("bp_next_borrow", borrow_out, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_next_done", in_ready, 1);

        // Reset abort mid-shift
        a = 8'h55;
        b = 8'h22;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_diff", diff, 8'h00);
        chk("abort_borrow", borrow_out, 0);
        chk("abort_overflow", overflow, 0);
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 12; s++) begin
            step();
            chk("abort_no_valid", out_valid, 0);
        end
        run_op(8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0);

        // Random sweep with random stalls
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rd = ra - rb;
            sd = int'($signed(ra)) - int'($signed(rb));
            run_op(ra, rb, int'($urandom_range(0, 3)), rd, (ra < rb),
                   (sd > 127) || (sd < -128));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
